// File: rtl/clk_reset_gen_if.sv
// Control/status bundle for the multi-channel clock divider and reset sequencer.
// The master drives ratio loads, enables and soft resets; the slave returns clocks, resets and load status.
interface clk_reset_gen_if #(
   parameter int NUM_CH = 2,
   parameter int DIV_W  = 8
);
   logic [NUM_CH*DIV_W-1:0] div_ratio;
   logic [NUM_CH-1:0]       div_load;
   logic [NUM_CH-1:0]       ch_en;
   logic [NUM_CH-1:0]       soft_rst;
   logic [NUM_CH-1:0]       clk_out;
   logic [NUM_CH-1:0]       ch_reset_n;
   logic [NUM_CH-1:0]       load_pend;

   modport master (
      output div_ratio, div_load, ch_en, soft_rst,
      input  clk_out, ch_reset_n, load_pend
   );

   modport slave (
      input  div_ratio, div_load, ch_en, soft_rst,
      output clk_out, ch_reset_n, load_pend
   );
endinterface

// File: rtl/clk_reset_gen.sv
// Multi-channel mclk divider with glitch-free ratio changes, wrap-point gating and
// per-channel stretched, optionally ordered resets. Everything is clocked by mclk.
module clk_reset_gen #(
   parameter int NUM_CH      = 2,
   parameter int DIV_W       = 8,
   parameter int DIV_DEFAULT = 2,
   parameter int RST_STRETCH = 16,
   parameter int SEQ_EN      = 1
) (
   input  logic           mclk,
   input  logic           w_Reset_MCLKsync_n,
   clk_reset_gen_if.slave bus
);
   localparam int              STR_W     = $clog2(RST_STRETCH + 1);
   localparam logic [DIV_W-1:0] DEF_RATIO = DIV_W'(DIV_DEFAULT);
   localparam logic [DIV_W-1:0] MIN_RATIO = DIV_W'(2);
   localparam logic [STR_W-1:0] STR_MAX   = STR_W'(RST_STRETCH);

   logic [NUM_CH-1:0] clear_vec;
   logic [NUM_CH-1:0] clk_vec;
   logic [NUM_CH-1:0] rst_vec;
   logic [NUM_CH-1:0] pend_vec;

   // With sequencing, a soft reset on a channel also restarts every later channel.
   always_comb begin : clear_gen
      logic upstream;
      upstream  = 1'b0;
      clear_vec = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         clear_vec[i] = bus.soft_rst[i] | ((SEQ_EN != 0) && upstream);
         upstream     = upstream | bus.soft_rst[i];
      end
   end

   assign bus.clk_out    = clk_vec;
   assign bus.ch_reset_n = rst_vec;
   assign bus.load_pend  = pend_vec;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [DIV_W-1:0] cnt;
      logic [DIV_W-1:0] ratio;
      logic [DIV_W-1:0] shadow;
      logic [DIV_W-1:0] req;
      logic [DIV_W-1:0] req_clamped;
      logic [DIV_W-1:0] cnt_nxt;
      logic [STR_W-1:0] str_cnt;
      logic             pend;
      logic             clk_q;
      logic             rst_n_q;
      logic             clk_nxt;
      logic             hold;
      logic             wrap;
      logic             rise;
      logic             fall;
      logic             eligible;

      if (SEQ_EN != 0 && i > 0) begin : g_seq
         assign eligible = rst_vec[i-1];
      end else begin : g_free
         assign eligible = 1'b1;
      end

      assign req         = bus.div_ratio[i*DIV_W +: DIV_W];
      assign req_clamped = (req < MIN_RATIO) ? MIN_RATIO : req;

      // A disabled channel only parks at cnt==0, so a period in flight always completes.
      always_comb begin
         hold    = (cnt == '0) && !bus.ch_en[i];
         wrap    = !hold && (cnt == ratio - DIV_W'(1));
         cnt_nxt = cnt + DIV_W'(1);
         if (hold || wrap) begin
            cnt_nxt = '0;
         end
         clk_nxt = !hold && (cnt < (ratio >> 1));
         rise    = clk_nxt && !clk_q;
         fall    = clk_q && !clk_nxt;
      end

      always_ff @(posedge mclk or negedge w_Reset_MCLKsync_n) begin
         if (!w_Reset_MCLKsync_n) begin
            cnt     <= '0;
            ratio   <= DEF_RATIO;
            shadow  <= DEF_RATIO;
            pend    <= 1'b0;
            clk_q   <= 1'b0;
            rst_n_q <= 1'b0;
            str_cnt <= '0;
         end else begin
            cnt   <= cnt_nxt;
            clk_q <= clk_nxt;

            if (wrap && pend) begin
               ratio <= shadow;
            end
            if (bus.div_load[i]) begin
               shadow <= req_clamped;
               pend   <= 1'b1;
            end else if (wrap) begin
               pend <= 1'b0;
            end

            // Release only on a falling output edge so the reset never lands mid high phase.
            if (clear_vec[i]) begin
               rst_n_q <= 1'b0;
               str_cnt <= '0;
            end else if (!rst_n_q) begin
               if (rise && eligible && (str_cnt != STR_MAX)) begin
                  str_cnt <= str_cnt + STR_W'(1);
               end
               if (fall && (str_cnt == STR_MAX)) begin
                  rst_n_q <= 1'b1;
               end
            end
         end
      end

      assign clk_vec[i]  = clk_q;
      assign rst_vec[i]  = rst_n_q;
      assign pend_vec[i] = pend;
   end
endmodule

// File: tb/tb_clk_reset_gen.sv
// Directed bench for clk_reset_gen: a vector table for startup and ratio changes, then
// hand sequences for gating, global reset and soft reset ordering (SEQ_EN=1 and SEQ_EN=0).
module tb_clk_reset_gen;
   logic mclk;
   logic w_Reset_MCLKsync_n;
   int   tests_run;
   int   failures;

   clk_reset_gen_if #(.NUM_CH(2), .DIV_W(8)) bus0 ();
   clk_reset_gen_if #(.NUM_CH(2), .DIV_W(8)) bus1 ();

   clk_reset_gen #(
      .NUM_CH(2), .DIV_W(8), .DIV_DEFAULT(2), .RST_STRETCH(4), .SEQ_EN(1)
   ) dut0 (
      .mclk(mclk),
      .w_Reset_MCLKsync_n(w_Reset_MCLKsync_n),
      .bus(bus0.slave)
   );

   clk_reset_gen #(
      .NUM_CH(2), .DIV_W(8), .DIV_DEFAULT(2), .RST_STRETCH(4), .SEQ_EN(0)
   ) dut1 (
      .mclk(mclk),
      .w_Reset_MCLKsync_n(w_Reset_MCLKsync_n),
      .bus(bus1.slave)
   );

   assign bus1.div_ratio = bus0.div_ratio;
   assign bus1.div_load  = bus0.div_load;
   assign bus1.ch_en     = bus0.ch_en;
   assign bus1.soft_rst  = bus0.soft_rst;

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct packed {
      logic [1:0] load;
      logic [7:0] r0;
      logic [7:0] r1;
      logic [1:0] clk;
      logic [1:0] rstn;
      logic [1:0] pend;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] load, input logic [7:0] r0, input logic [7:0] r1,
                               input logic [1:0] clk, input logic [1:0] rstn, input logic [1:0] pend);
      vec_t v;
      v.load = load; v.r0 = r0; v.r1 = r1;
      v.clk = clk; v.rstn = rstn; v.pend = pend;
      return v;
   endfunction

   task automatic applyStimulus(input logic [1:0] load, input logic [1:0] en, input logic [1:0] srst,
                                input logic [7:0] r0, input logic [7:0] r1);
      bus0.div_load  = load;
      bus0.ch_en     = en;
      bus0.soft_rst  = srst;
      bus0.div_ratio = {r1, r0};
      @(posedge mclk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(2'b00, 2'b11, 2'b00, 8'd0, 8'd0);
   endtask

   task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
      tests_run++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %b required %b", name, actual, expected);
      end
   endtask

   vec_t vecs [39];

   initial begin
      logic [7:0] gate_exp;
      tests_run = 0;
      failures  = 0;

      // Startup: N=2 both channels, ch1 released after ch0 (edges 8 and 16).
      for (int e = 1; e <= 19; e++) begin
         vecs[e-1] = mk(2'b00, 8'd0, 8'd0, (e % 2 == 1) ? 2'b11 : 2'b00,
                        {e >= 16, e >= 8}, 2'b00);
      end
      // Ratio 5 on ch0, ratio 1 (clamped to 2) on ch1, captured on edge 20.
      vecs[19] = mk(2'b11, 8'd5, 8'd1, 2'b00, 2'b11, 2'b11);
      vecs[20] = mk(2'b00, 8'd0, 8'd0, 2'b11, 2'b11, 2'b11);
      vecs[21] = mk(2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 2'b00);
      vecs[22] = mk(2'b00, 8'd0, 8'd0, 2'b11, 2'b11, 2'b00);
      vecs[23] = mk(2'b00, 8'd0, 8'd0, 2'b01, 2'b11, 2'b00);
      vecs[24] = mk(2'b00, 8'd0, 8'd0, 2'b10, 2'b11, 2'b00);
      vecs[25] = mk(2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 2'b00);
      vecs[26] = mk(2'b00, 8'd0, 8'd0, 2'b10, 2'b11, 2'b00);
      vecs[27] = mk(2'b00, 8'd0, 8'd0, 2'b01, 2'b11, 2'b00);
      // ch0: 4 then 6 inside one N=5 period; ch1: ratio 0 clamped to 2.
      vecs[28] = mk(2'b11, 8'd4, 8'd0, 2'b11, 2'b11, 2'b11);
      vecs[29] = mk(2'b01, 8'd6, 8'd0, 2'b00, 2'b11, 2'b01);
      vecs[30] = mk(2'b00, 8'd0, 8'd0, 2'b10, 2'b11, 2'b01);
      vecs[31] = mk(2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 2'b00);
      vecs[32] = mk(2'b00, 8'd0, 8'd0, 2'b11, 2'b11, 2'b00);
      vecs[33] = mk(2'b00, 8'd0, 8'd0, 2'b01, 2'b11, 2'b00);
      vecs[34] = mk(2'b00, 8'd0, 8'd0, 2'b11, 2'b11, 2'b00);
      vecs[35] = mk(2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 2'b00);
      vecs[36] = mk(2'b00, 8'd0, 8'd0, 2'b10, 2'b11, 2'b00);
      vecs[37] = mk(2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 2'b00);
      vecs[38] = mk(2'b00, 8'd0, 8'd0, 2'b11, 2'b11, 2'b00);

      w_Reset_MCLKsync_n = 1'b0;
      bus0.div_load  = 2'b00;
      bus0.ch_en     = 2'b11;
      bus0.soft_rst  = 2'b00;
      bus0.div_ratio = 16'h0;
      repeat (3) @(posedge mclk);
      #1;
      checkOutput("rst_clk", bus0.clk_out, 2'b00);
      checkOutput("rst_rstn", bus0.ch_reset_n, 2'b00);
      checkOutput("rst_pend", bus0.load_pend, 2'b00);
      w_Reset_MCLKsync_n = 1'b1;

      for (int i = 0; i < 39; i++) begin
         applyStimulus(vecs[i].load, 2'b11, 2'b00, vecs[i].r0, vecs[i].r1);
         checkOutput($sformatf("vec%0d_clk", i + 1), bus0.clk_out, vecs[i].clk);
         checkOutput($sformatf("vec%0d_rstn", i + 1), bus0.ch_reset_n, vecs[i].rstn);
         checkOutput($sformatf("vec%0d_pend", i + 1), bus0.load_pend, vecs[i].pend);
      end

      // Gating ch1 at N=6: load on edge 40, applied at the wrap on edge 42.
      applyStimulus(2'b10, 2'b11, 2'b00, 8'd0, 8'd6);
      checkOutput("gate_pend_set", 2'(bus0.load_pend[1]), 2'b01);
      idle();
      idle();
      checkOutput("gate_pend_clr", 2'(bus0.load_pend[1]), 2'b00);
      idle();
      checkOutput("gate_first_high", 2'(bus0.clk_out[1]), 2'b01);
      gate_exp = 8'b0000_0011;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(2'b00, 2'b01, (k == 2) ? 2'b10 : 2'b00, 8'd0, 8'd0);
         checkOutput($sformatf("gate_clk_%0d", k), 2'(bus0.clk_out[1]), 2'(gate_exp[k]));
      end
      checkOutput("gate_srst_rstn", bus0.ch_reset_n, 2'b01);
      idle();
      checkOutput("gate_reenable", 2'(bus0.clk_out[1]), 2'b01);
      repeat (20) idle();
      checkOutput("gate_stretch_hold", bus0.ch_reset_n, 2'b01);
      idle();
      checkOutput("gate_stretch_rel", bus0.ch_reset_n, 2'b11);

      // Global reset mid-period with a load pending.
      applyStimulus(2'b01, 2'b11, 2'b00, 8'd9, 8'd0);
      checkOutput("grst_pend_before", bus0.load_pend, 2'b01);
      #3;
      w_Reset_MCLKsync_n = 1'b0;
      #1;
      checkOutput("grst_clk", bus0.clk_out, 2'b00);
      checkOutput("grst_rstn", bus0.ch_reset_n, 2'b00);
      checkOutput("grst_pend", bus0.load_pend, 2'b00);
      idle();
      idle();
      checkOutput("grst_held_clk", bus0.clk_out, 2'b00);
      w_Reset_MCLKsync_n = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         idle();
         checkOutput($sformatf("post_clk_%0d", e), bus0.clk_out, (e % 2 == 1) ? 2'b11 : 2'b00);
         checkOutput($sformatf("post_rstn_%0d", e), bus0.ch_reset_n, {e >= 16, e >= 8});
         checkOutput($sformatf("post_rstn_noseq_%0d", e), bus1.ch_reset_n, {e >= 8, e >= 8});
      end
      checkOutput("post_pend", bus0.load_pend, 2'b00);

      // soft_rst[0] on a falling output edge: ordered restart vs independent channels.
      idle();
      applyStimulus(2'b00, 2'b11, 2'b01, 8'd0, 8'd0);
      checkOutput("srst_seq_fall", bus0.ch_reset_n, 2'b00);
      checkOutput("srst_noseq_fall", bus1.ch_reset_n, 2'b10);
      for (int k = 1; k <= 16; k++) begin
         idle();
         checkOutput($sformatf("srst_seq_%0d", k), bus0.ch_reset_n, {k >= 16, k >= 8});
         checkOutput($sformatf("srst_noseq_%0d", k), bus1.ch_reset_n, {1'b1, k >= 8});
      end

      // A soft reset on the release edge keeps the reset asserted and restarts the count.
      idle();
      applyStimulus(2'b00, 2'b11, 2'b01, 8'd0, 8'd0);
      repeat (7) idle();
      applyStimulus(2'b00, 2'b11, 2'b01, 8'd0, 8'd0);
      checkOutput("srst_wins", 2'(bus0.ch_reset_n[0]), 2'b00);
      repeat (7) idle();
      checkOutput("srst_wins_hold", 2'(bus0.ch_reset_n[0]), 2'b00);
      idle();
      checkOutput("srst_wins_rel", 2'(bus0.ch_reset_n[0]), 2'b01);

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end
endmodule

// File: doc/clk_reset_gen.md
Name: clk_reset_gen

Overview:
Parametrised multi-channel clock divider and reset sequencer. It replaces the fixed divide-by-2, two-domain generator. From mclk it produces NUM_CH divided clocks with runtime-programmable ratios, glitch-free ratio changes and per-channel clock gating. It also produces one reset per channel; each reset is stretched, ordered between channels and deasserted on the falling edge of that channel's own clock. It sits at the top of the camera/serial design, after the mclk reset synchroniser.

Parameters:
NUM_CH, 2, number of output clock/reset channels (1..8)
DIV_W, 8, width of each divide-ratio field
DIV_DEFAULT, 2, divide ratio loaded at reset (>=2)
RST_STRETCH, 16, output-clock rising edges counted before a channel reset deasserts (>=1)
SEQ_EN, 1, 1 = channel i waits for channel i-1 to deassert; 0 = channels independent

Ports:
mclk  in  1  master clock
w_Reset_MCLKsync_n  in  1  asynchronous active-low reset, already synchronised to mclk
div_ratio  in  NUM_CH*DIV_W  requested ratio per channel; field i = bits [i*DIV_W +: DIV_W]
div_load  in  NUM_CH  one-cycle pulse per channel; captures that channel's div_ratio field
ch_en  in  NUM_CH  clock enable per channel
soft_rst  in  NUM_CH  one-cycle pulse per channel; restarts that channel's reset sequence
clk_out  out  NUM_CH  divided clocks
ch_reset_n  out  NUM_CH  active-low channel resets
load_pend  out  NUM_CH  high while a captured ratio is waiting to be applied

Behaviour:
- Decided: reset w_Reset_MCLKsync_n, asynchronous, active-low; clock mclk. All state is in the mclk domain; no logic is clocked by clk_out.
- Values during reset: clk_out=0, ch_reset_n=0, load_pend=0, cnt=0, active ratio N=DIV_DEFAULT, shadow=DIV_DEFAULT, stretch counters=0.
- Divider, per channel:
  - Counter cnt runs 0..N-1 and wraps to 0.
  - Registered clk_out <= (cnt < N>>1). clk_out is high for floor(N/2) mclk cycles per period.
  - Example, N=2: clk_out rises on mclk edges 1,3,5,... after reset release.
- Ratio clamp: a loaded value below 2 is stored as 2.
- Ratio change:
  - div_load[i] captures the field into the shadow register and sets load_pend[i] on the next edge.
  - The shadow value becomes the active ratio N on the edge where cnt wraps N-1 -> 0. load_pend clears on that same edge.
  - No runt pulses are allowed.
  - A second div_load before the wrap overwrites the shadow (last value wins).
- Gating:
  - ch_en[i]=0 stops the channel only at the wrap point: cnt is held at 0 and clk_out at 0.
  - A pending ratio is still applied at that wrap.
  - When ch_en returns high, clk_out rises on the next edge.
  - A ch_en drop mid-period completes the current period first.
- Reset stretch:
  - Each channel has a saturating counter of clk_out 0->1 transitions.
  - The counter advances only while ch_reset_n[i]=0 and the channel is eligible.
  - Eligible means SEQ_EN=0, or i=0, or ch_reset_n[i-1]=1.
  - Once the count reaches RST_STRETCH, ch_reset_n[i] deasserts on the mclk edge that drives clk_out[i] 1->0.
- soft_rst:
  - soft_rst[i] drives ch_reset_n[i]=0 on the next edge and clears its stretch counter. The divider keeps running.
  - With SEQ_EN=1, all channels j>i also reassert and clear on the same edge.
  - A soft_rst on the same cycle as deassertion wins (the reset stays asserted).
- Simultaneous soft_rst and div_load: both take effect independently.
- Global reset mid-operation: everything returns to reset values immediately (asynchronously).

Test Plan:
- Defaults, NUM_CH=2, DIV_DEFAULT=2, RST_STRETCH=4, SEQ_EN=1; release reset -> clk_out[0] and clk_out[1] rise on edges 1,3,5,7; ch_reset_n[0] rises on edge 8; ch_reset_n[1] rises on edge 16.
- div_load[0] with ratio 5 on edge 20 (N=2 running) -> load_pend[0]=1 until the next wrap, then clk_out[0] is high 2 cycles and low 3 cycles, with no pulse shorter than 1 cycle. Ratio 0 or 1 -> behaves as 2.
- Two div_load pulses (4, then 6) inside one period -> the period after the wrap is 6; ratio 4 never appears.
- ch_en[1] low mid-period with N=6 -> the current period completes, then clk_out[1] is held 0. Re-enable -> rises on the next edge. The stretch counter is frozen while gated.
- soft_rst[0] after both resets are released (N=2) -> ch_reset_n[0] and ch_reset_n[1] fall on the next edge; channel 0 releases after 4 rises, channel 1 after 4 more. With SEQ_EN=0 -> only channel 0 is affected.
- Assert w_Reset_MCLKsync_n low mid-period with a load pending -> all outputs are 0 immediately and load_pend=0. After release, ratio=DIV_DEFAULT.
